// File: rtl/sar_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sar_ctrl_fsm                                              |
// | Brief    : Synchronous SAR sequencer: sample phase, MSB-first binary |
// |            search with per-bit comparator timeout, continuous mode.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sar_ctrl_fsm #(
   parameter int NBITS      = 10,
   parameter int SAMPLE_CYC = 4,
   parameter int TIMEOUT    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cont,
   input  logic             cmp_valid,
   input  logic             cmp_out,
   output logic             sample,
   output logic             cmp_clk,
   output logic [NBITS-1:0] step,
   output logic [NBITS-1:0] dac_code,
   output logic [NBITS-1:0] dout,
   output logic             done,
   output logic             busy,
   output logic             timeout_flag
);

   localparam int c_SCW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
   localparam int c_TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int c_IW  = $clog2(NBITS);
   localparam logic [c_SCW-1:0] c_SCNT_INIT = c_SCW'(SAMPLE_CYC - 1);
   localparam logic [c_TW-1:0]  c_WCNT_LAST = c_TW'(TIMEOUT - 1);
   localparam logic [c_IW-1:0]  c_IDX_MSB   = c_IW'(NBITS - 1);
   localparam logic [NBITS-1:0] c_MSB       = {1'b1, {(NBITS-1){1'b0}}};

   // One-hot encoding; bit positions below are used for direct flop decodes.
   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_SAMPLE = 5'b00010,
      S_FIRE   = 5'b00100,
      S_WAIT   = 5'b01000,
      S_FINISH = 5'b10000
   } state_t;

   localparam int c_B_IDLE   = 0;
   localparam int c_B_SAMPLE = 1;
   localparam int c_B_FIRE   = 2;
   localparam int c_B_WAIT   = 3;
   localparam int c_B_FINISH = 4;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_SCW-1:0]   r_scnt;
   logic [c_TW-1:0]    r_wcnt;
   logic [c_IW-1:0]    r_idx;
   logic [NBITS-1:0]   r_code;
   logic [NBITS-1:0]   r_dout;
   logic               r_to_acc;
   logic               r_to_flag;
   logic               w_force;
   logic               w_decide;
   logic               w_load;
   logic [c_IW-1:0]    w_idx_m1;
   logic [NBITS-1:0]   w_code_dec;
   logic [NBITS-1:0]   w_next_trial;
   logic [NBITS-1:0]   w_step;

   // cmp_valid on the last allowed WAIT cycle still beats the forced decision.
   assign w_force  = r_state[c_B_WAIT] && !cmp_valid && (r_wcnt == c_WCNT_LAST);
   assign w_decide = r_state[c_B_WAIT] && (cmp_valid || w_force);
   assign w_load   = (r_state[c_B_IDLE] && start) ||
                     (r_state[c_B_FINISH] && (start || cont));
   assign w_idx_m1 = r_idx - 1'b1;

   always_comb begin
      w_code_dec        = r_code;
      w_code_dec[r_idx] = cmp_valid & cmp_out;
      w_next_trial      = '0;
      if (r_idx != '0)
         w_next_trial[w_idx_m1] = 1'b1;
      w_step = '0;
      if (r_state[c_B_FIRE] || r_state[c_B_WAIT])
         w_step[r_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (start) w_state_nxt = S_SAMPLE;
         S_SAMPLE: if (r_scnt == '0) w_state_nxt = S_FIRE;
         S_FIRE:   w_state_nxt = S_WAIT;
         S_WAIT:   if (w_decide) w_state_nxt = (r_idx == '0) ? S_FINISH : S_FIRE;
         S_FINISH: w_state_nxt = (start || cont) ? S_SAMPLE : S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scnt    <= '0;
         r_wcnt    <= '0;
         r_idx     <= '0;
         r_code    <= '0;
         r_dout    <= '0;
         r_to_acc  <= 1'b0;
         r_to_flag <= 1'b0;
      end else begin
         if (w_load) begin
            r_scnt   <= c_SCNT_INIT;
            r_code   <= '0;
            r_to_acc <= 1'b0;
         end
         if (r_state[c_B_SAMPLE]) begin
            if (r_scnt == '0) begin
               r_idx  <= c_IDX_MSB;
               r_code <= c_MSB;
            end else begin
               r_scnt <= r_scnt - 1'b1;
            end
         end
         if (r_state[c_B_FIRE])
            r_wcnt <= '0;
         if (r_state[c_B_WAIT]) begin
            if (w_decide) begin
               if (w_force)
                  r_to_acc <= 1'b1;
               // Result registers load on FINISH entry so dout is valid alongside done.
               if (r_idx == '0) begin
                  r_code    <= w_code_dec;
                  r_dout    <= w_code_dec;
                  r_to_flag <= r_to_acc | w_force;
               end else begin
                  r_idx  <= w_idx_m1;
                  r_code <= w_code_dec | w_next_trial;
               end
            end else begin
               r_wcnt <= r_wcnt + 1'b1;
            end
         end
      end
   end

   assign sample       = r_state[c_B_SAMPLE];
   assign cmp_clk      = r_state[c_B_FIRE];
   assign done         = r_state[c_B_FINISH];
   assign busy         = ~r_state[c_B_IDLE];
   assign step         = w_step;
   assign dac_code     = r_code;
   assign dout         = r_dout;
   assign timeout_flag = r_to_flag;

endmodule
`default_nettype wire

// File: tb/tb_sar_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sar_ctrl_fsm                                           |
// | Brief    : Scoreboard bench for sar_ctrl_fsm with comparator model.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_sar_ctrl_fsm;

   localparam int NBITS = 10;

   logic             clk = 1'b0;
   logic             rst, start, cont, cmp_valid, cmp_out;
   logic             sample, cmp_clk, done, busy, timeout_flag;
   logic [NBITS-1:0] step, dac_code, dout;

   sar_ctrl_fsm #(.NBITS(NBITS), .SAMPLE_CYC(4), .TIMEOUT(8)) u_dut (
      .clk(clk), .rst(rst), .start(start), .cont(cont),
      .cmp_valid(cmp_valid), .cmp_out(cmp_out),
      .sample(sample), .cmp_clk(cmp_clk), .step(step), .dac_code(dac_code),
      .dout(dout), .done(done), .busy(busy), .timeout_flag(timeout_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NBITS-1:0] dout;
      logic             tf;
      int               t0;
      int               lat;
   } exp_t;

   exp_t             sb_q[$];
   exp_t             e;
   int               checks = 0;
   int               failures = 0;
   int               cyc = 0;
   int               n_s = 0;
   int               n_f = 0;
   int               wcnt = 0;
   logic [NBITS-1:0] target = '0;
   logic [NBITS-1:0] hold_mask = '0;
   logic [NBITS-1:0] late_mask = '0;
   bit               stray = 1'b0;
   bit               rand_cmp = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sample)  n_s = n_s + 1;
      if (cmp_clk) n_f = n_f + 1;
   end

   // Comparator model: decides at the end of the first WAIT cycle unless the bit is held/late.
   always @(negedge clk) begin
      cmp_valid = 1'b0;
      cmp_out   = 1'b0;
      if (rand_cmp) begin
         cmp_valid = 1'($urandom);
         cmp_out   = 1'($urandom);
      end else if (cmp_clk || sample) begin
         if (cmp_clk) wcnt = 0;
         if (stray) begin
            cmp_valid = 1'b1;
            cmp_out   = 1'b1;
         end
      end else if (step != '0) begin
         wcnt = wcnt + 1;
         if ((step & hold_mask) != '0) begin
            cmp_valid = 1'b0;
         end else if ((step & late_mask) != '0) begin
            if (wcnt == 8) begin
               cmp_valid = 1'b1;
               cmp_out   = |(step & target);
            end
         end else begin
            cmp_valid = 1'b1;
            cmp_out   = |(step & target);
         end
      end
   end

   // Monitor: every done pulse pops one expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk("dout", 64'(dout), 64'(e.dout));
            chk("timeout_flag", 64'(timeout_flag), 64'(e.tf));
            chk("done_latency", 64'(cyc - e.t0), 64'(e.lat));
         end
      end
   end

   task automatic start_conv(input logic [NBITS-1:0] tgt, input logic [NBITS-1:0] hold,
                             input logic [NBITS-1:0] late, input bit str, input bit push,
                             input logic [NBITS-1:0] dexp, input logic tfexp, input int lat,
                             output int t0);
      @(negedge clk);
      target    = tgt;
      hold_mask = hold;
      late_mask = late;
      stray     = str;
      t0        = cyc;
      if (push) sb_q.push_back('{dexp, tfexp, cyc, lat});
      n_s   = 0;
      n_f   = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int max);
      bit seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) chk("done_timeout", 64'd0, 64'd1);
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({sample, cmp_clk, step, dac_code, dout, done, busy, timeout_flag});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int bad;
      bit seen;
      rst = 1'b1; start = 1'b0; cont = 1'b0; rand_cmp = 1'b1;
      // Reset with random inputs.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_outputs", all_outs(), 64'd0);
         start = 1'($urandom);
         cont  = 1'($urandom);
      end
      @(negedge clk);
      start = 1'b0; cont = 1'b0; rand_cmp = 1'b0; rst = 1'b0;

      // Nominal conversion.
      start_conv(10'h2B5, '0, '0, 1'b0, 1'b1, 10'h2B5, 1'b0, 25, t0);
      wait_done(100);
      chk("sample_cycles", 64'(n_s), 64'd4);
      chk("cmp_clk_pulses", 64'(n_f), 64'd10);
      @(negedge clk);
      chk("idle_after_done", 64'(busy), 64'd0);

      // Bit 5 forced by timeout.
      start_conv(10'h2B5, 10'h020, '0, 1'b0, 1'b1, 10'h295, 1'b1, 32, t0);
      wait_done(100);
      @(negedge clk);
      chk("dac_code_hold", 64'(dac_code), 64'h295);

      // Continuous mode, two back-to-back conversions.
      cont = 1'b1;
      start_conv(10'h3FF, '0, '0, 1'b0, 1'b1, 10'h3FF, 1'b0, 25, t0);
      sb_q.push_back('{10'h000, 1'b0, t0 + 25, 25});
      bad  = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (!busy) bad++;
         if (done) seen = 1'b1;
      end
      target = 10'h000;
      @(negedge clk);
      cont = 1'b0;
      if (!busy) bad++;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (!busy) bad++;
         if (done) seen = 1'b1;
      end
      chk("cont_second_done", 64'(seen), 64'd1);
      chk("busy_cont", 64'(bad), 64'd0);
      @(negedge clk);
      chk("idle_after_cont", 64'(busy), 64'd0);

      // Abort while bit 6 is under trial.
      start_conv(10'h155, '0, '0, 1'b0, 1'b0, '0, 1'b0, 0, t0);
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (step[6]) seen = 1'b1;
      end
      chk("reached_step6", 64'(seen), 64'd1);
      rst = 1'b1;
      #1;
      chk("abort_outputs", all_outs(), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      start_conv(10'h155, '0, '0, 1'b0, 1'b1, 10'h155, 1'b0, 25, t0);
      wait_done(100);

      // Stray strobes, start while busy, decision on the last timeout cycle.
      start_conv(10'h2B5, '0, 10'h010, 1'b1, 1'b1, 10'h2B5, 1'b0, 32, t0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (8) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done(100);
      stray = 1'b0;
      @(negedge clk);
      chk("start_not_queued", 64'(busy), 64'd0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
